// File: rtl/beta_pkg.sv
// Shared types and constants for the beta pipeline hazard controller.
package beta_pkg;

  localparam int unsigned HC_STATE_W = 2;

  typedef enum logic [HC_STATE_W-1:0] {
    StRun      = 2'd0,
    StLoadWait = 2'd1,
    StBusyWait = 2'd2,
    StFlush    = 2'd3
  } hc_state_t;

endpackage

// File: rtl/beta_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module beta_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/beta_hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding, load-use/busy stalls, redirect flush,
// plus a saturating count of stall cycles.
module beta_hazard_ctrl
  import beta_pkg::*;
#(
  parameter int unsigned StallCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     hc_dec_valid_i,
  input  logic [4:0]               hc_rs1_addr_i,
  input  logic [4:0]               hc_rs2_addr_i,
  input  logic                     hc_rs1_used_i,
  input  logic                     hc_rs2_used_i,
  input  logic [4:0]               hc_wb_rd_addr_i,
  input  logic                     hc_wb_wr_en_i,
  input  logic                     hc_ld_pending_i,
  input  logic [4:0]               hc_ld_rd_addr_i,
  input  logic                     hc_ld_done_i,
  input  logic                     hc_exe_busy_i,
  input  logic                     hc_redirect_i,
  output logic                     hc_forward_en_o,
  output logic [1:0]               hc_forward_src_o,
  output logic                     hc_stall_o,
  output logic                     hc_bubble_o,
  output logic                     hc_flush_o,
  output logic [HC_STATE_W-1:0]    hc_state_o,
  output logic [StallCntWidth-1:0] hc_stall_cnt_o
);

  hc_state_t state_q, state_d;

  logic raw1, raw2, load_use;
  logic [1:0] fwd_match;
  logic stall, bubble, flush, fwd_allow;
  logic [StallCntWidth-1:0] stall_cnt;

  // Register x0 is hardwired to zero, so it never participates in a dependency.
  assign raw1 = hc_rs1_used_i & (hc_rs1_addr_i != 5'd0);
  assign raw2 = hc_rs2_used_i & (hc_rs2_addr_i != 5'd0);

  assign load_use = hc_dec_valid_i & hc_ld_pending_i &
                    ((raw1 & (hc_rs1_addr_i == hc_ld_rd_addr_i)) |
                     (raw2 & (hc_rs2_addr_i == hc_ld_rd_addr_i)));

  assign fwd_match[0] = raw1 & hc_wb_wr_en_i & (hc_rs1_addr_i == hc_wb_rd_addr_i);
  assign fwd_match[1] = raw2 & hc_wb_wr_en_i & (hc_rs2_addr_i == hc_wb_rd_addr_i);

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    fwd_allow = 1'b0;
    unique case (state_q)
      StRun: begin
        fwd_allow = 1'b1;
        if (hc_redirect_i) begin
          state_d = StFlush;
        end else if (hc_exe_busy_i) begin
          stall   = 1'b1;
          state_d = StBusyWait;
        end else if (load_use) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = StLoadWait;
        end
      end
      StLoadWait: begin
        fwd_allow = 1'b1;
        if (hc_redirect_i) begin
          state_d = StFlush;
        end else if (hc_ld_done_i) begin
          // Load data is on the write port now, so decode proceeds using the forward path.
          state_d = StRun;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      StBusyWait: begin
        if (hc_redirect_i) begin
          state_d = StFlush;
        end else if (!hc_exe_busy_i) begin
          state_d = StRun;
        end else begin
          stall = 1'b1;
        end
      end
      StFlush: begin
        flush   = 1'b1;
        bubble  = 1'b1;
        state_d = hc_redirect_i ? StFlush : StRun;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is held at zero while reset is asserted, whatever the inputs are doing.
  assign hc_stall_o       = stall & ~rst_i;
  assign hc_bubble_o      = bubble & ~rst_i;
  assign hc_flush_o       = flush & ~rst_i;
  assign hc_forward_src_o = (fwd_allow & ~rst_i) ? fwd_match : 2'b00;
  assign hc_forward_en_o  = |hc_forward_src_o;
  assign hc_state_o       = rst_i ? '0 : state_q;
  assign hc_stall_cnt_o   = rst_i ? '0 : stall_cnt;

  beta_sat_counter #(
    .Width(StallCntWidth)
  ) u_stall_cnt (
    .clk_i(clk_i),
    .clr_i(rst_i),
    .en_i (hc_stall_o),
    .cnt_o(stall_cnt)
  );

endmodule

// File: tb/tb_beta_hazard_ctrl.sv
// Directed scoreboard bench for beta_hazard_ctrl; a narrow second instance checks saturation.
module tb_beta_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       dec_valid, rs1_used, rs2_used, wb_wr_en, ld_pending, ld_done, exe_busy, redirect;
  logic [4:0] rs1, rs2, wb_rd, ld_rd;

  logic        fwd_en, stall, bubble, flush;
  logic [1:0]  fwd_src, state;
  logic [15:0] cnt;

  logic        s_fwd_en, s_stall, s_bubble, s_flush;
  logic [1:0]  s_fwd_src, s_state;
  logic [2:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  st;
    logic        stl;
    logic        bub;
    logic        fl;
    logic [1:0]  fs;
    logic        fe;
    logic [15:0] cnt;
    logic [2:0]  scnt;
  } exp_t;

  exp_t sb[$];
  int   cnt_model  = 0;
  int   scnt_model = 0;

  always #5 clk_i = ~clk_i;

  beta_hazard_ctrl #(.StallCntWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hc_dec_valid_i(dec_valid),
    .hc_rs1_addr_i(rs1), .hc_rs2_addr_i(rs2), .hc_rs1_used_i(rs1_used),
    .hc_rs2_used_i(rs2_used), .hc_wb_rd_addr_i(wb_rd), .hc_wb_wr_en_i(wb_wr_en),
    .hc_ld_pending_i(ld_pending), .hc_ld_rd_addr_i(ld_rd), .hc_ld_done_i(ld_done),
    .hc_exe_busy_i(exe_busy), .hc_redirect_i(redirect),
    .hc_forward_en_o(fwd_en), .hc_forward_src_o(fwd_src), .hc_stall_o(stall),
    .hc_bubble_o(bubble), .hc_flush_o(flush), .hc_state_o(state), .hc_stall_cnt_o(cnt)
  );

  beta_hazard_ctrl #(.StallCntWidth(3)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .hc_dec_valid_i(dec_valid),
    .hc_rs1_addr_i(rs1), .hc_rs2_addr_i(rs2), .hc_rs1_used_i(rs1_used),
    .hc_rs2_used_i(rs2_used), .hc_wb_rd_addr_i(wb_rd), .hc_wb_wr_en_i(wb_wr_en),
    .hc_ld_pending_i(ld_pending), .hc_ld_rd_addr_i(ld_rd), .hc_ld_done_i(ld_done),
    .hc_exe_busy_i(exe_busy), .hc_redirect_i(redirect),
    .hc_forward_en_o(s_fwd_en), .hc_forward_src_o(s_fwd_src), .hc_stall_o(s_stall),
    .hc_bubble_o(s_bubble), .hc_flush_o(s_flush), .hc_state_o(s_state),
    .hc_stall_cnt_o(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dec_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0; wb_wr_en = 1'b0;
    ld_pending = 1'b0; ld_done = 1'b0; exe_busy = 1'b0; redirect = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; wb_rd = 5'd0; ld_rd = 5'd0;
  endtask

  // Inputs for this cycle are already driven; push expectations, compare mid-cycle, advance.
  task automatic step(input string tag, input logic [1:0] st, input logic stl,
                      input logic bub, input logic fl, input logic [1:0] fs);
    exp_t e, o;
    e.st   = st;
    e.stl  = stl;
    e.bub  = bub;
    e.fl   = fl;
    e.fs   = fs;
    e.fe   = |fs;
    e.cnt  = rst_i ? 16'd0 : 16'(cnt_model);
    e.scnt = rst_i ? 3'd0 : 3'(scnt_model);
    sb.push_back(e);
    @(negedge clk_i);
    o = sb.pop_front();
    chk({tag, ".state"},   32'(state),   32'(o.st));
    chk({tag, ".stall"},   32'(stall),   32'(o.stl));
    chk({tag, ".bubble"},  32'(bubble),  32'(o.bub));
    chk({tag, ".flush"},   32'(flush),   32'(o.fl));
    chk({tag, ".fwd_src"}, 32'(fwd_src), 32'(o.fs));
    chk({tag, ".fwd_en"},  32'(fwd_en),  32'(o.fe));
    chk({tag, ".cnt"},     32'(cnt),     32'(o.cnt));
    chk({tag, ".cnt_sat"}, 32'(s_cnt),   32'(o.scnt));
    @(posedge clk_i);
    if (rst_i) begin
      cnt_model  = 0;
      scnt_model = 0;
    end else if (stl) begin
      if (cnt_model < 65535) cnt_model++;
      if (scnt_model < 7) scnt_model++;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    // Reset with aggressive inputs: everything must read zero.
    rst_i = 1'b1; exe_busy = 1'b1; redirect = 1'b1; dec_valid = 1'b1;
    rs1 = 5'd5; rs1_used = 1'b1; wb_rd = 5'd5; wb_wr_en = 1'b1;
    @(posedge clk_i); #1;
    step("rst_hold", 2'd0, 0, 0, 0, 2'b00);
    rst_i = 1'b0; clear_inputs();
    step("idle", 2'd0, 0, 0, 0, 2'b00);

    // Forwarding from the write port.
    dec_valid = 1'b1; rs1 = 5'd5; rs1_used = 1'b1; wb_rd = 5'd5; wb_wr_en = 1'b1;
    step("fwd_rs1", 2'd0, 0, 0, 0, 2'b01);
    clear_inputs(); dec_valid = 1'b1; rs2 = 5'd9; rs2_used = 1'b1; wb_rd = 5'd9; wb_wr_en = 1'b1;
    step("fwd_rs2", 2'd0, 0, 0, 0, 2'b10);
    rs1 = 5'd9; rs1_used = 1'b1;
    step("fwd_both", 2'd0, 0, 0, 0, 2'b11);

    // x0 never forwards nor stalls.
    clear_inputs(); dec_valid = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
    wb_wr_en = 1'b1; ld_pending = 1'b1;
    step("x0", 2'd0, 0, 0, 0, 2'b00);

    // Load-use on rs2, three waiting cycles, then load completion.
    clear_inputs(); dec_valid = 1'b1; rs2 = 5'd7; rs2_used = 1'b1; ld_pending = 1'b1; ld_rd = 5'd7;
    step("lu_detect", 2'd0, 1, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++) step("lu_wait", 2'd1, 1, 1, 0, 2'b00);
    ld_done = 1'b1; wb_rd = 5'd7; wb_wr_en = 1'b1;
    step("lu_done", 2'd1, 0, 0, 0, 2'b10);
    clear_inputs();
    step("lu_back", 2'd0, 0, 0, 0, 2'b00);

    // Invalid decode must not stall on a matching load.
    rs2 = 5'd7; rs2_used = 1'b1; ld_pending = 1'b1; ld_rd = 5'd7;
    step("nodec", 2'd0, 0, 0, 0, 2'b00);

    // Busy for five cycles; forwarding is masked while waiting.
    clear_inputs(); exe_busy = 1'b1;
    step("busy_first", 2'd0, 1, 0, 0, 2'b00);
    rs1 = 5'd5; rs1_used = 1'b1; wb_rd = 5'd5; wb_wr_en = 1'b1;
    for (int i = 0; i < 4; i++) step("busy_wait", 2'd2, 1, 0, 0, 2'b00);
    exe_busy = 1'b0;
    step("busy_release", 2'd2, 0, 0, 0, 2'b00);
    clear_inputs();
    step("busy_back", 2'd0, 0, 0, 0, 2'b00);

    // Redirect while in LOAD_WAIT.
    dec_valid = 1'b1; rs1 = 5'd3; rs1_used = 1'b1; ld_pending = 1'b1; ld_rd = 5'd3;
    step("lr_detect", 2'd0, 1, 1, 0, 2'b00);
    redirect = 1'b1;
    step("lr_redirect", 2'd1, 0, 0, 0, 2'b00);
    clear_inputs();
    step("lr_flush", 2'd3, 0, 1, 1, 2'b00);
    step("lr_back", 2'd0, 0, 0, 0, 2'b00);

    // Redirect beats load-use in RUN; repeated redirect holds FLUSH; no forwarding there.
    dec_valid = 1'b1; rs1 = 5'd3; rs1_used = 1'b1; ld_pending = 1'b1; ld_rd = 5'd3;
    redirect = 1'b1;
    step("rd_run", 2'd0, 0, 0, 0, 2'b00);
    clear_inputs(); redirect = 1'b1; rs1 = 5'd4; rs1_used = 1'b1; wb_rd = 5'd4; wb_wr_en = 1'b1;
    step("rd_flush1", 2'd3, 0, 1, 1, 2'b00);
    redirect = 1'b0;
    step("rd_flush2", 2'd3, 0, 1, 1, 2'b00);
    clear_inputs();
    step("rd_back", 2'd0, 0, 0, 0, 2'b00);

    // Busy outranks load-use; redirect during BUSY_WAIT goes to FLUSH.
    dec_valid = 1'b1; rs1 = 5'd3; rs1_used = 1'b1; ld_pending = 1'b1; ld_rd = 5'd3;
    exe_busy = 1'b1;
    step("bl_prio", 2'd0, 1, 0, 0, 2'b00);
    redirect = 1'b1;
    step("bl_redirect", 2'd2, 0, 0, 0, 2'b00);
    clear_inputs();
    step("bl_flush", 2'd3, 0, 1, 1, 2'b00);
    step("bl_back", 2'd0, 0, 0, 0, 2'b00);

    // Reset in the middle of BUSY_WAIT.
    exe_busy = 1'b1;
    step("rb_enter", 2'd0, 1, 0, 0, 2'b00);
    step("rb_wait", 2'd2, 1, 0, 0, 2'b00);
    rst_i = 1'b1;
    step("rb_reset", 2'd0, 0, 0, 0, 2'b00);
    rst_i = 1'b0; exe_busy = 1'b0;
    step("rb_after", 2'd0, 0, 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/beta_hazard_ctrl.md
BETA_HAZARD_CTRL -- requirements
Module: beta_hazard_ctrl

Interface
REQ-001 SHALL have parameter: StallCntWidth, 16, width of saturating stall-cycle counter.
REQ-002 SHALL have ports (one clock; reset synchronous, active-high):
clk_i  in  1  core clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
hc_dec_valid_i  in  1  decode holds a valid instruction
hc_rs1_addr_i  in  5  decoded source register 1 address
hc_rs2_addr_i  in  5  decoded source register 2 address
hc_rs1_used_i  in  1  instruction reads rs1
hc_rs2_used_i  in  1  instruction reads rs2
hc_wb_rd_addr_i  in  5  regfile write-port address this cycle
hc_wb_wr_en_i  in  1  regfile write-port enable this cycle
hc_ld_pending_i  in  1  a load is outstanding in the memory stage
hc_ld_rd_addr_i  in  5  destination of the outstanding load
hc_ld_done_i  in  1  load data is on the write port this cycle
hc_exe_busy_i  in  1  exe stage executing a multi-cycle op
hc_redirect_i  in  1  taken branch/jump/trap, PC redirected
hc_forward_en_o  out  1  decode operand forward enable
hc_forward_src_o  out  2  bit0 forward to operand A, bit1 to operand B
hc_stall_o  out  1  hold IF and decode registers
hc_bubble_o  out  1  inject NOP into exe stage
hc_flush_o  out  1  squash IF/decode contents
hc_state_o  out  2  current FSM state, for debug
hc_stall_cnt_o  out  StallCntWidth  stall cycles since reset

Function
REQ-003 SHALL implement FSM states RUN(0), LOAD_WAIT(1), BUSY_WAIT(2), FLUSH(3); hc_state_o = current state.
REQ-004 SHALL define raw1 = hc_rs1_used_i & rs1!=0; raw2 likewise for rs2; x0 never creates a hazard or forward.
REQ-005 SHALL define load_use = hc_dec_valid_i & hc_ld_pending_i & ((raw1 & rs1==ld_rd) | (raw2 & rs2==ld_rd)).
REQ-006 SHALL compute forward_src[0] = raw1 & hc_wb_wr_en_i & rs1==wb_rd, forward_src[1] likewise for rs2, combinationally, in RUN and LOAD_WAIT only; forced 0 in FLUSH and BUSY_WAIT.
REQ-007 SHALL drive hc_forward_en_o = |hc_forward_src_o.
REQ-008 RUN transitions, priority order: hc_redirect_i -> FLUSH; hc_exe_busy_i -> BUSY_WAIT; load_use -> LOAD_WAIT; else stay.
REQ-009 In RUN, hc_stall_o and hc_bubble_o SHALL assert combinationally in the same cycle load_use=1 (unless redirect); hc_stall_o alone in the same cycle hc_exe_busy_i=1.
REQ-010 LOAD_WAIT: stall=1, bubble=1; redirect -> FLUSH; else hc_ld_done_i=1 -> stall=0, bubble=0 that cycle, forward from write port active, next state RUN.
REQ-011 BUSY_WAIT: stall=1, bubble=0; redirect -> FLUSH; hc_exe_busy_i=0 -> stall=0 that cycle, next state RUN.
REQ-012 FLUSH: flush=1, bubble=1, stall=0, exactly one cycle, then RUN; redirect again in FLUSH -> remain FLUSH another cycle.
REQ-013 Redirect SHALL override every stall source in the same cycle (stall=0, flush=1 next cycle).
REQ-014 Stall counter SHALL increment by 1 each cycle hc_stall_o=1, saturate at all-ones, never wrap.
REQ-015 Decode with hc_dec_valid_i=0 SHALL never cause stall or state change other than redirect/busy.

Reset
REQ-016 rst_i=1 at a clock edge SHALL force RUN and clear the counter, including mid-LOAD_WAIT/BUSY_WAIT/FLUSH.
REQ-017 While rst_i=1, all outputs SHALL be 0 irrespective of inputs.

Structure
REQ-018 hc_state_t enum and HC_STATE_W constant SHALL live in beta_pkg.
REQ-019 The saturating counter SHALL be sub-module beta_sat_counter (parameterised width, enable, sync clear).
REQ-020 Comparators SHALL be combinational; only FSM state and counter are registered.

Verification
REQ-021 rs1=5 used, wb_rd=5, wb_wr_en=1 -> forward_src=01, forward_en=1, stall=0, same cycle.
REQ-022 rs2=7 used, ld_pending=1, ld_rd=7 -> stall=1,bubble=1 same cycle; LOAD_WAIT 3 cycles; ld_done with wb_rd=7 -> stall=0, forward_src=10, RUN; counter=4.
REQ-023 rs1=0 used, wb_rd=0, wb_wr_en=1, ld_rd=0 pending -> no forward, no stall.
REQ-024 exe_busy=1 for 5 cycles -> stall=1 for 5 cycles, bubble=0, back to RUN on deassert.
REQ-025 LOAD_WAIT with redirect=1 -> next cycle flush=1, bubble=1, stall=0; following cycle RUN.
REQ-026 rst_i=1 during BUSY_WAIT -> next cycle state=0, counter=0, all outputs 0; counter forced near max saturates at all-ones.
